// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared state encoding and datapath select codes for the multicycle ARM controller (HALT exists only with ARM_MC_UNDEF_TRAP_EN)
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        st_fetch  = 4'd0,
        st_decode = 4'd1,
        st_memadr = 4'd2,
        st_memrd  = 4'd3,
        st_memwb  = 4'd4,
        st_memwr  = 4'd5,
        st_execr  = 4'd6,
        st_execi  = 4'd7,
        st_aluwb  = 4'd8,
`ifdef ARM_MC_UNDEF_TRAP_EN
        st_branch = 4'd9,
        st_halt   = 4'd10
`else
        st_branch = 4'd9
`endif
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/arm_alu_dec.sv
// arm_alu_dec: combinational data-processing decode of Funct into ALU op, raw flag-write enables and NoWrite
module arm_alu_dec
    import arm_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [1:0] alu_control,
    output logic [1:0] flag_write,
    output logic       no_write
);

    logic [3:0] cmd;
    logic       s_bit, is_add, is_sub, is_and, is_orr, is_cmp, known;

    assign cmd    = funct[4:1];
    assign s_bit  = funct[0];
    assign is_add = cmd == 4'b0100;
    assign is_sub = cmd == 4'b0010;
    assign is_and = cmd == 4'b0000;
    assign is_orr = cmd == 4'b1100;
    assign is_cmp = cmd == 4'b1010;
    assign known  = is_add | is_sub | is_and | is_orr | is_cmp;

    // CMP shares the subtractor; unknown commands fall back to add and never write
    assign alu_control = is_sub | is_cmp ? ALU_SUB :
                         is_and          ? ALU_AND :
                         is_orr          ? ALU_ORR : ALU_ADD;
    assign no_write    = ~known | is_cmp;
    assign flag_write  = is_cmp ? 2'b11 :
                         ~known ? 2'b00 : {s_bit, s_bit & (is_add | is_sub)};

endmodule

// File: rtl/arm_mc_ctrl_fsm.sv
// arm_mc_ctrl_fsm: multicycle ARM main FSM with ALU decode; ARM_MC_UNDEF_TRAP_EN turns Op=11 into a sticky HALT
module arm_mc_ctrl_fsm
    import arm_ctrl_pkg::*;
#(
    parameter bit FETCH_PC_INC = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       CondEx,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       undef,
    output logic [3:0] state
);

`ifdef ARM_MC_UNDEF_TRAP_EN
    localparam state_t OP11_NEXT = st_halt;
`else
    localparam state_t OP11_NEXT = st_fetch;
`endif

    state_t     cur, nxt;
    logic [1:0] dec_alu, dec_flag;
    logic       no_write, rd15;

    assign rd15  = Rd == 4'd15;
    assign state = cur;

`ifdef ARM_MC_UNDEF_TRAP_EN
    assign undef = cur == st_halt;
`else
    assign undef = 1'b0;
`endif

    arm_alu_dec u_alu_dec (
        .funct       (Funct),
        .alu_control (dec_alu),
        .flag_write  (dec_flag),
        .no_write    (no_write)
    );

    // state register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur <= st_fetch;
        else          cur <= nxt;
    end

    // next state and Moore outputs, with strobes gated by CondEx/mem_ready and held low in reset
    always_comb begin
        nxt        = cur;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        FlagWrite  = 2'b00;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        case (cur)
            st_fetch: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                IRWrite   = mem_ready;
                PCWrite   = FETCH_PC_INC & mem_ready;
                nxt       = mem_ready ? st_decode : st_fetch;
            end
            st_decode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                nxt       = Op == OP_MEM ? st_memadr :
                            Op == OP_DP  ? (Funct[5] ? st_execi : st_execr) :
                            Op == OP_BR  ? st_branch : OP11_NEXT;
            end
            st_memadr: begin
                ALUSrcB = SRCB_IMM;
                nxt     = Funct[0] ? st_memrd : st_memwr;
            end
            st_memrd: begin
                AdrSrc = 1'b1;
                nxt    = mem_ready ? st_memwb : st_memrd;
            end
            st_memwb: begin
                ResultSrc = RES_DATA;
                RegWrite  = CondEx;
                PCWrite   = CondEx & rd15;
                nxt       = st_fetch;
            end
            st_memwr: begin
                AdrSrc   = 1'b1;
                MemWrite = CondEx & mem_ready;
                nxt      = mem_ready ? st_fetch : st_memwr;
            end
            st_execr: begin
                ALUControl = dec_alu;
                nxt        = st_aluwb;
            end
            st_execi: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = dec_alu;
                nxt        = st_aluwb;
            end
            st_aluwb: begin
                ALUControl = dec_alu;
                FlagWrite  = dec_flag;
                RegWrite   = CondEx & ~no_write;
                PCWrite    = CondEx & ~no_write & rd15;
                nxt        = st_fetch;
            end
            st_branch: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURES;
                PCWrite   = CondEx;
                nxt       = st_fetch;
            end
`ifdef ARM_MC_UNDEF_TRAP_EN
            st_halt: nxt = st_halt;
`endif
            default: nxt = st_fetch;
        endcase
        if (!reset_n) begin
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            RegWrite  = 1'b0;
            MemWrite  = 1'b0;
            FlagWrite = 2'b00;
        end
    end

endmodule

// File: tb/tb_arm_mc_ctrl_fsm.sv
// tb_arm_mc_ctrl_fsm: directed plus randomized check of arm_mc_ctrl_fsm against an instruction-path model; honours ARM_MC_UNDEF_TRAP_EN
module tb_arm_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       CondEx, mem_ready;
    logic       IRWrite, AdrSrc, ALUSrcA, PCWrite, RegWrite, MemWrite, undef;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagWrite;
    logic [3:0] state;

    int vectors = 0;
    int miscompares = 0;
    int m_state = 0;
    int m_q[$];

    always #5 clk = ~clk;

    arm_mc_ctrl_fsm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .CondEx     (CondEx),
        .mem_ready  (mem_ready),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .FlagWrite  (FlagWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .undef      (undef),
        .state      (state)
    );

    // Model: each instruction is a list of states chosen at fetch from its class;
    // memory-touching steps (0, 3, 5) wait on mem_ready. Outputs follow the per-state table.
    always @(negedge clk) begin
        logic [3:0]  cmd;
        logic        sb_f, nw, rd15, irw, adr, sa, pcw, rw, mw, ud;
        logic [1:0]  ac, dfw, srcb, rs, acx, fw;
        logic [18:0] exp_v, act_v;
        if (!reset_n) begin
            m_state = 0;
            m_q.delete();
        end
        cmd  = Funct[4:1];
        sb_f = Funct[0];
        rd15 = Rd == 4'd15;
        nw = 1'b1; ac = 2'd0; dfw = 2'd0;
        case (cmd)
            4'b0100: begin ac = 2'd0; nw = 1'b0; dfw = {sb_f, sb_f}; end
            4'b0010: begin ac = 2'd1; nw = 1'b0; dfw = {sb_f, sb_f}; end
            4'b0000: begin ac = 2'd2; nw = 1'b0; dfw = {sb_f, 1'b0}; end
            4'b1100: begin ac = 2'd3; nw = 1'b0; dfw = {sb_f, 1'b0}; end
            4'b1010: begin ac = 2'd1; nw = 1'b1; dfw = 2'b11; end
            default: ;
        endcase
        {irw, adr, sa, srcb, rs, acx, fw, pcw, rw, mw, ud} = '0;
        case (m_state)
            0: begin sa = 1; srcb = 2; rs = 2; irw = mem_ready; pcw = mem_ready; end
            1: begin sa = 1; srcb = 2; rs = 2; end
            2: srcb = 1;
            3: adr = 1;
            4: begin rs = 1; rw = CondEx; pcw = CondEx & rd15; end
            5: begin adr = 1; mw = CondEx & mem_ready; end
            6: acx = ac;
            7: begin srcb = 1; acx = ac; end
            8: begin acx = ac; fw = dfw; rw = CondEx & ~nw; pcw = CondEx & ~nw & rd15; end
            9: begin srcb = 1; rs = 2; pcw = CondEx; end
            10: ud = 1;
            default: ;
        endcase
        if (!reset_n) {irw, pcw, rw, mw, fw} = '0;
        exp_v = {irw, adr, sa, srcb, rs, acx, fw, pcw, rw, mw, ud, 4'(m_state)};
        act_v = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagWrite,
                 PCWrite, RegWrite, MemWrite, undef, state};
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL cycle t=%0t model_state=%0d op=%b funct=%b: got %h want %h",
                     $time, m_state, Op, Funct, act_v, exp_v);
        end
        if (reset_n) begin
            if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) ;
            else if (m_state == 10) ;
            else if (m_state == 0) begin
                case (Op)
                    2'b00: if (Funct[5]) m_q = '{1, 7, 8}; else m_q = '{1, 6, 8};
                    2'b01: if (Funct[0]) m_q = '{1, 2, 3, 4}; else m_q = '{1, 2, 5};
                    2'b10: m_q = '{1, 9};
                    default: begin
`ifdef ARM_MC_UNDEF_TRAP_EN
                        m_q = '{1, 10};
`else
                        m_q = '{1};
`endif
                    end
                endcase
                m_state = m_q.pop_front();
            end
            else m_state = m_q.size() > 0 ? m_q.pop_front() : 0;
        end
    end

    task automatic lit(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                       input logic cx, input logic mr);
        @(posedge clk);
        #1;
        Op = op; Funct = f; Rd = rd; CondEx = cx; mem_ready = mr;
        #2;
    endtask

    initial begin
        reset_n = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; CondEx = 1'b0; mem_ready = 1'b0;
        #1 reset_n = 1'b0;
        cyc(2'b00, 6'd0, 4'd0, 1'b1, 1'b1);
        lit("rst_state", 8'(state), 8'd0);
        lit("rst_irwrite", 8'(IRWrite), 8'd0);
        lit("rst_pcwrite", 8'(PCWrite), 8'd0);
        lit("rst_srcb", 8'(ALUSrcB), 8'd2);
        lit("rst_undef", 8'(undef), 8'd0);
        cyc(2'b00, 6'd0, 4'd0, 1'b1, 1'b0);
        reset_n = 1'b1;

        // ADDS R1,R2,R3
        cyc(2'b00, 6'b001001, 4'd1, 1'b1, 1'b1);
        lit("adds_fetch", 8'(state), 8'd0);
        lit("adds_irwrite", 8'(IRWrite), 8'd1);
        cyc(2'b00, 6'b001001, 4'd1, 1'b1, 1'b1);
        lit("adds_decode", 8'(state), 8'd1);
        cyc(2'b00, 6'b001001, 4'd1, 1'b1, 1'b1);
        lit("adds_execr", 8'(state), 8'd6);
        cyc(2'b00, 6'b001001, 4'd1, 1'b1, 1'b1);
        lit("adds_aluwb", 8'(state), 8'd8);
        lit("adds_aluctl", 8'(ALUControl), 8'd0);
        lit("adds_regwrite", 8'(RegWrite), 8'd1);
        lit("adds_flagwrite", 8'(FlagWrite), 8'd3);
        lit("adds_pcwrite", 8'(PCWrite), 8'd0);

        // CMP R0,#5
        cyc(2'b00, 6'b110101, 4'd0, 1'b1, 1'b1);
        lit("adds_back_fetch", 8'(state), 8'd0);
        cyc(2'b00, 6'b110101, 4'd0, 1'b1, 1'b1);
        cyc(2'b00, 6'b110101, 4'd0, 1'b1, 1'b1);
        lit("cmp_execi", 8'(state), 8'd7);
        cyc(2'b00, 6'b110101, 4'd0, 1'b1, 1'b1);
        lit("cmp_aluctl", 8'(ALUControl), 8'd1);
        lit("cmp_regwrite", 8'(RegWrite), 8'd0);
        lit("cmp_flagwrite", 8'(FlagWrite), 8'd3);

        // LDR with three wait cycles in MEMRD
        cyc(2'b01, 6'b011001, 4'd2, 1'b1, 1'b1);
        cyc(2'b01, 6'b011001, 4'd2, 1'b1, 1'b1);
        cyc(2'b01, 6'b011001, 4'd2, 1'b1, 1'b1);
        lit("ldr_memadr", 8'(state), 8'd2);
        for (int i = 0; i < 3; i++) begin
            cyc(2'b01, 6'b011001, 4'd2, 1'b1, 1'b0);
            lit("ldr_memrd_wait", 8'(state), 8'd3);
        end
        cyc(2'b01, 6'b011001, 4'd2, 1'b1, 1'b1);
        lit("ldr_memrd_done", 8'(state), 8'd3);
        cyc(2'b01, 6'b011001, 4'd2, 1'b1, 1'b1);
        lit("ldr_memwb", 8'(state), 8'd4);
        lit("ldr_regwrite", 8'(RegWrite), 8'd1);
        lit("ldr_resultsrc", 8'(ResultSrc), 8'd1);

        // STR with failed condition
        cyc(2'b01, 6'b011000, 4'd3, 1'b0, 1'b1);
        cyc(2'b01, 6'b011000, 4'd3, 1'b0, 1'b1);
        cyc(2'b01, 6'b011000, 4'd3, 1'b0, 1'b1);
        cyc(2'b01, 6'b011000, 4'd3, 1'b0, 1'b0);
        lit("str_memwr_wait", 8'(state), 8'd5);
        lit("str_memwrite_wait", 8'(MemWrite), 8'd0);
        cyc(2'b01, 6'b011000, 4'd3, 1'b0, 1'b1);
        lit("str_memwrite_ready", 8'(MemWrite), 8'd0);

        // B taken, then B not taken
        for (int k = 0; k < 2; k++) begin
            cyc(2'b10, 6'd0, 4'd0, 1'(1 - k), 1'b1);
            lit("b_fetch", 8'(state), 8'd0);
            cyc(2'b10, 6'd0, 4'd0, 1'(1 - k), 1'b1);
            cyc(2'b10, 6'd0, 4'd0, 1'(1 - k), 1'b1);
            lit("b_branch", 8'(state), 8'd9);
            lit("b_pcwrite", 8'(PCWrite), 8'(1 - k));
        end

        // reset pulsed during EXECR
        cyc(2'b00, 6'b001000, 4'd4, 1'b1, 1'b1);
        cyc(2'b00, 6'b001000, 4'd4, 1'b1, 1'b1);
        cyc(2'b00, 6'b001000, 4'd4, 1'b1, 1'b1);
        lit("rstmid_execr", 8'(state), 8'd6);
        reset_n = 1'b0;
        #1;
        lit("rstmid_state", 8'(state), 8'd0);
        cyc(2'b00, 6'b001000, 4'd4, 1'b1, 1'b1);
        lit("rstmid_hold", 8'(state), 8'd0);
        lit("rstmid_regwrite", 8'(RegWrite), 8'd0);
        lit("rstmid_pcwrite", 8'(PCWrite), 8'd0);
        cyc(2'b00, 6'b001000, 4'd4, 1'b1, 1'b0);
        reset_n = 1'b1;

`ifndef ARM_MC_UNDEF_TRAP_EN
        // Op=11 is a no-op: back to fetch right after decode
        cyc(2'b11, 6'd0, 4'd0, 1'b1, 1'b1);
        cyc(2'b11, 6'd0, 4'd0, 1'b1, 1'b1);
        lit("op11_decode", 8'(state), 8'd1);
        cyc(2'b11, 6'd0, 4'd0, 1'b1, 1'b0);
        lit("op11_nop_fetch", 8'(state), 8'd0);
        lit("op11_undef", 8'(undef), 8'd0);
`endif

        // randomized instruction stream with occasional reset pulses
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            reset_n = $urandom_range(0, 249) != 0;
            if (m_state == 0) begin
`ifdef ARM_MC_UNDEF_TRAP_EN
                Op = 2'($urandom_range(0, 2));
`else
                Op = 2'($urandom_range(0, 3));
`endif
                Funct = 6'($urandom);
                if ($urandom_range(0, 4) != 0) begin
                    case ($urandom_range(0, 4))
                        0: Funct[4:1] = 4'b0100;
                        1: Funct[4:1] = 4'b0010;
                        2: Funct[4:1] = 4'b0000;
                        3: Funct[4:1] = 4'b1100;
                        default: Funct[4:1] = 4'b1010;
                    endcase
                end
                Rd = $urandom_range(0, 3) == 0 ? 4'd15 : 4'($urandom);
            end
            CondEx = 1'($urandom);
            mem_ready = $urandom_range(0, 3) != 0;
        end
        @(posedge clk);
        #1 reset_n = 1'b1;

`ifdef ARM_MC_UNDEF_TRAP_EN
        // bring the FSM back to fetch, then trap on Op=11
        cyc(2'b00, 6'd0, 4'd0, 1'b0, 1'b0);
        reset_n = 1'b0;
        cyc(2'b00, 6'd0, 4'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        cyc(2'b11, 6'd0, 4'd15, 1'b1, 1'b1);
        cyc(2'b11, 6'd0, 4'd15, 1'b1, 1'b1);
        cyc(2'b11, 6'd0, 4'd15, 1'b1, 1'b1);
        lit("halt_state", 8'(state), 8'd10);
        lit("halt_undef", 8'(undef), 8'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(2'b00, 6'b001001, 4'd15, 1'b1, 1'b1);
            lit("halt_hold", 8'(state), 8'd10);
            lit("halt_undef_sticky", 8'(undef), 8'd1);
            lit("halt_pcwrite", 8'(PCWrite), 8'd0);
        end
        cyc(2'b00, 6'd0, 4'd0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        lit("halt_reset_undef", 8'(undef), 8'd0);
        lit("halt_reset_state", 8'(state), 8'd0);
        cyc(2'b00, 6'd0, 4'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
`endif

        cyc(2'b00, 6'd0, 4'd0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arm_mc_ctrl_fsm.md
Name: arm_mc_ctrl_fsm

Overview:
- Multicycle ARM control unit: main FSM plus ALU decoder. Sits directly upstream of the condition-check stage.
- Drives raw FlagWrite[1:0] into condition check; consumes its CondEx to gate PC, register and memory writes.
- Sequences fetch/decode/execute/writeback over 3–5 cycles per instruction.
- Stretches memory states with a mem_ready handshake.

Parameters:
- FETCH_PC_INC, 1, assert PC write during FETCH; the datapath computes PC+4.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- Op  in  2  instr[27:26]
- Funct  in  6  instr[25:20]; [5]=I, [4:1]=cmd, [0]=S or L
- Rd  in  4  instr[15:12]
- CondEx  in  1  from condition check, same cycle
- mem_ready  in  1  memory access completes this cycle
- IRWrite  out  1  instruction register load
- AdrSrc  out  1  0=PC, 1=ALUOut
- ALUSrcA  out  1  0=RegA, 1=PC
- ALUSrcB  out  2  00=RegB, 01=ExtImm, 10=const 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUControl  out  2  00 add, 01 sub, 10 and, 11 orr
- FlagWrite  out  2  [1]=NZ, [0]=CV, ungated; condition check applies CondEx
- PCWrite  out  1  PC load
- RegWrite  out  1  register file write, CondEx-gated
- MemWrite  out  1  memory write, CondEx-gated
- undef  out  1  sticky undefined-op flag
- state  out  4  current state encoding, debug

Behaviour:
- Reset (async, reset_n=0): state=FETCH. All outputs reflect FETCH decode, except undef=0. Reset mid-instruction aborts it; no write strobe is asserted while reset_n=0.
- Outputs are Moore (functions of state) except:
  - ALUControl and FlagWrite also depend on Funct.
  - Write strobes also depend on CondEx and mem_ready.
- Default for every output not listed under a state: 0.
- FETCH (0):
  - Outputs: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, IRWrite=mem_ready, PCWrite=mem_ready.
  - Transition: to DECODE when mem_ready=1, else hold.
- DECODE (1):
  - Outputs: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 for R15 reads).
  - Transitions: Op=01 → MEMADR; Op=00 & Funct[5]=0 → EXECR; Op=00 & Funct[5]=1 → EXECI; Op=10 → BRANCH; Op=11 → FETCH (see Optional Feature).
- MEMADR (2):
  - Outputs: ALUSrcA=0, ALUSrcB=01, ALUControl=00.
  - Transitions: Funct[0]=1 → MEMRD, else → MEMWR.
- MEMRD (3): AdrSrc=1. Transition to MEMWB on mem_ready, else hold.
- MEMWB (4): ResultSrc=01, RegWrite=CondEx, PCWrite=CondEx & (Rd==15). Transition to FETCH.
- MEMWR (5): AdrSrc=1, MemWrite=CondEx & mem_ready. Transition to FETCH on mem_ready, else hold.
- EXECR (6): ALUSrcA=0, ALUSrcB=00, ALU decode active. Transition to ALUWB.
- EXECI (7): ALUSrcA=0, ALUSrcB=01, ALU decode active. Transition to ALUWB.
- ALUWB (8):
  - ALU decode held active.
  - ResultSrc=00.
  - RegWrite=CondEx & ~NoWrite.
  - PCWrite=CondEx & ~NoWrite & (Rd==15).
  - FlagWrite per ALU decode; asserted only in this state.
  - Transition to FETCH.
- BRANCH (9): ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=CondEx. Transition to FETCH.
- ALU decode, on Funct[4:1]:
  - 0100 → add (00)
  - 0010 → sub (01)
  - 0000 → and (10)
  - 1100 → orr (11)
  - 1010 → CMP: sub (01) with NoWrite=1
  - Any other cmd: ALUControl=00, FlagWrite=00, NoWrite=1.
- Flag writes: FlagWrite[1]=Funct[0]; FlagWrite[0]=Funct[0] & (add|sub). CMP forces FlagWrite=11.
- Failed condition (CondEx=0): the instruction still walks all its states; only the strobes are suppressed.
- Unused state encodings (10–15) go to FETCH.

Optional Feature:
- Macro: ARM_MC_UNDEF_TRAP_EN.
- When defined:
  - DECODE with Op=11 → HALT (10).
  - HALT holds forever; all strobes are 0.
  - undef=1 from the first HALT cycle until reset.
- When undefined:
  - Op=11 → FETCH, executing as a no-op.
  - undef is tied to 0; HALT does not exist.

Decomposition:
- Package arm_ctrl_pkg holds:
  - the state enum (4-bit);
  - localparams for ALUControl, ALUSrcB and ResultSrc codes;
  - Op codes DP=00, MEM=01, BR=10.
- One sub-module, arm_alu_dec: takes Funct; produces ALUControl, FlagWrite and NoWrite (combinational). It is instantiated in the FSM.

Test Plan:
- ADDS R1,R2,R3 (Op=00, Funct=001001, Rd=1), CondEx=1, mem_ready=1 → FETCH, DECODE, EXECR, ALUWB; ALUControl=00, RegWrite=1 and FlagWrite=11 in ALUWB; back in FETCH on the 5th cycle.
- CMP R0,#5 (Funct=110101) → ALUControl=01, RegWrite=0, FlagWrite=11 in ALUWB.
- LDR with mem_ready low 3 cycles in MEMRD (Funct[0]=1) → MEMRD held 4 cycles, then MEMWB with RegWrite=1, ResultSrc=01.
- STR with CondEx=0 → MEMWR reached, MemWrite stays 0, returns to FETCH on mem_ready.
- B with CondEx=1, then with CondEx=0 → PCWrite=1 in BRANCH for the first; 0 for the second.
- reset_n pulsed low during EXECR → state=0 immediately, no RegWrite pulse. With ARM_MC_UNDEF_TRAP_EN: Op=11 gives state=10, undef=1 held until reset.
